// File: rtl/cmd_responder.sv
// rtl/cmd_responder.sv - card-side SD command responder: capture, validate, dispatch to core, return response
// Optional: CMD_LEGAL_CHECK_EN enables rejection of indices whose LEGAL_MASK bit is 0.
module cmd_responder #(
  parameter int          RESP_TIMEOUT = 1024,
  parameter logic [63:0] LEGAL_MASK   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        strobe_in,
  input  logic [39:0] cmd_in,
  input  logic        serial_ready,
  input  logic        ack_in,
  output logic        ack_out,
  output logic        strobe_out,
  output logic [39:0] resp_out,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_argument,
  input  logic        core_resp_valid,
  input  logic [31:0] core_resp,
  output logic        busy,
  output logic        frame_error,
  output logic        index_error,
  output logic        resp_timeout
);

  localparam int CW = $clog2(RESP_TIMEOUT) + 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(RESP_TIMEOUT - 1);
  localparam logic [31:0]   ILLEGAL_COMMAND = 32'h0040_0000;

  typedef enum logic [2:0] {IDLE, DECODE, WAIT_CORE, SEND_RESP, WAIT_ACK} state_t;

  state_t        state, state_nxt;
  logic          strobe_q;
  logic [1:0]    start_q, start_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   resp_word, resp_word_nxt;

  logic        ack_nxt, strobe_out_nxt, cmd_valid_nxt, busy_nxt;
  logic        frame_error_nxt, index_error_nxt, resp_timeout_nxt;
  logic [39:0] resp_out_nxt;
  logic [5:0]  cmd_index_nxt;
  logic [31:0] cmd_argument_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      strobe_q     <= 1'b0;
      start_q      <= 2'b00;
      count        <= '0;
      resp_word    <= '0;
      ack_out      <= 1'b0;
      strobe_out   <= 1'b0;
      resp_out     <= '0;
      cmd_valid    <= 1'b0;
      cmd_index    <= '0;
      cmd_argument <= '0;
      busy         <= 1'b0;
      frame_error  <= 1'b0;
      index_error  <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      strobe_q     <= strobe_in;
      start_q      <= start_nxt;
      count        <= count_nxt;
      resp_word    <= resp_word_nxt;
      ack_out      <= ack_nxt;
      strobe_out   <= strobe_out_nxt;
      resp_out     <= resp_out_nxt;
      cmd_valid    <= cmd_valid_nxt;
      cmd_index    <= cmd_index_nxt;
      cmd_argument <= cmd_argument_nxt;
      busy         <= busy_nxt;
      frame_error  <= frame_error_nxt;
      index_error  <= index_error_nxt;
      resp_timeout <= resp_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    start_nxt        = start_q;
    count_nxt        = count;
    resp_word_nxt    = resp_word;
    ack_nxt          = 1'b0;
    cmd_valid_nxt    = 1'b0;
    frame_error_nxt  = 1'b0;
    index_error_nxt  = 1'b0;
    resp_timeout_nxt = 1'b0;
    strobe_out_nxt   = strobe_out;
    resp_out_nxt     = resp_out;
    cmd_index_nxt    = cmd_index;
    cmd_argument_nxt = cmd_argument;

    case (state)
      IDLE: begin
        // Only a fresh rising edge starts a command; a held level is ignored.
        if (strobe_in && !strobe_q) begin
          start_nxt        = cmd_in[39:38];
          cmd_index_nxt    = cmd_in[37:32];
          cmd_argument_nxt = cmd_in[31:0];
          ack_nxt          = 1'b1;
          state_nxt        = DECODE;
        end
      end
      DECODE: begin
        if (start_q != 2'b01) begin
          frame_error_nxt = 1'b1;
          state_nxt       = IDLE;
        end
`ifdef CMD_LEGAL_CHECK_EN
        else if (!LEGAL_MASK[cmd_index]) begin
          index_error_nxt = 1'b1;
          resp_word_nxt   = ILLEGAL_COMMAND;
          state_nxt       = SEND_RESP;
        end
`endif
        else begin
          cmd_valid_nxt = 1'b1;
          count_nxt     = '0;
          state_nxt     = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        // A response arriving on the timeout cycle still wins.
        if (core_resp_valid) begin
          resp_word_nxt = core_resp;
          state_nxt     = SEND_RESP;
        end else if (count == COUNT_LAST) begin
          resp_timeout_nxt = 1'b1;
          state_nxt        = IDLE;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      SEND_RESP: begin
        if (serial_ready) begin
          strobe_out_nxt = 1'b1;
          resp_out_nxt   = {2'b00, cmd_index, resp_word};
          state_nxt      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_in) begin
          strobe_out_nxt = 1'b0;
          resp_out_nxt   = '0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_cmd_responder.sv
// tb/tb_cmd_responder.sv - directed self-checking bench for cmd_responder
module tb_cmd_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        strobe_in;
  logic [39:0] cmd_in;
  logic        serial_ready;
  logic        ack_in;
  logic        ack_out;
  logic        strobe_out;
  logic [39:0] resp_out;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        core_resp_valid;
  logic [31:0] core_resp;
  logic        busy;
  logic        frame_error;
  logic        index_error;
  logic        resp_timeout;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cmd_responder #(
    .RESP_TIMEOUT(16),
    .LEGAL_MASK  (64'hFFFF_FFFF_FFFF_FFDF)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .strobe_in      (strobe_in),
    .cmd_in         (cmd_in),
    .serial_ready   (serial_ready),
    .ack_in         (ack_in),
    .ack_out        (ack_out),
    .strobe_out     (strobe_out),
    .resp_out       (resp_out),
    .cmd_valid      (cmd_valid),
    .cmd_index      (cmd_index),
    .cmd_argument   (cmd_argument),
    .core_resp_valid(core_resp_valid),
    .core_resp      (core_resp),
    .busy           (busy),
    .frame_error    (frame_error),
    .index_error    (index_error),
    .resp_timeout   (resp_timeout)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; strobe_in = 1'b0; cmd_in = '0; serial_ready = 1'b1;
    ack_in = 1'b0; core_resp_valid = 1'b0; core_resp = '0;
    step(); step();
    checks++;
    if ({ack_out, strobe_out, resp_out, cmd_valid, cmd_index, cmd_argument, busy,
         frame_error, index_error, resp_timeout} !== 85'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b strobe=%b resp=%h cv=%b busy=%b required all 0",
               ack_out, strobe_out, resp_out, cmd_valid, busy);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_normal();
    cmd_in = 40'h51_0000_1234; strobe_in = 1'b1;
    step();
    checks++;
    if ({ack_out, busy, cmd_valid} !== 3'b110) begin
      failures++; $display("FAIL normal_ack: got ack/busy/cv=%b required 110", {ack_out, busy, cmd_valid});
    end
    step();
    strobe_in = 1'b0;
    checks++;
    if ({ack_out, cmd_valid, cmd_index, cmd_argument} !== {1'b0, 1'b1, 6'd17, 32'h1234}) begin
      failures++; $display("FAIL normal_cmd_valid: got cv=%b idx=%0d arg=%h required cv=1 idx=17 arg=00001234",
                           cmd_valid, cmd_index, cmd_argument);
    end
    step();
    checks++;
    if (cmd_valid !== 1'b0) begin
      failures++; $display("FAIL normal_cv_pulse: got %b required 0", cmd_valid);
    end
    step();
    core_resp_valid = 1'b1; core_resp = 32'h0000_0900;
    step();
    core_resp_valid = 1'b0; core_resp = 32'hDEAD_BEEF;
    checks++;
    if (strobe_out !== 1'b0) begin
      failures++; $display("FAIL normal_strobe_early: got %b required 0", strobe_out);
    end
    step();
    checks++;
    if ({strobe_out, resp_out} !== {1'b1, 40'h11_0000_0900}) begin
      failures++; $display("FAIL normal_resp: got strobe=%b resp=%h required 1 1100000900", strobe_out, resp_out);
    end
    step(); step(); step();
    checks++;
    if ({strobe_out, resp_out} !== {1'b1, 40'h11_0000_0900}) begin
      failures++; $display("FAIL normal_resp_hold: got strobe=%b resp=%h required 1 1100000900", strobe_out, resp_out);
    end
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    checks++;
    if ({strobe_out, resp_out, busy} !== 42'd0) begin
      failures++; $display("FAIL normal_after_ack: got strobe=%b resp=%h busy=%b required 0 0 0", strobe_out, resp_out, busy);
    end
  endtask

  task automatic test_frame_error();
    cmd_in = 40'hD1_0000_0000; strobe_in = 1'b1;
    step();
    checks++;
    if (ack_out !== 1'b1) begin
      failures++; $display("FAIL frame_ack: got %b required 1", ack_out);
    end
    step();
    strobe_in = 1'b0;
    checks++;
    if ({frame_error, cmd_valid, busy, strobe_out} !== 4'b1000) begin
      failures++; $display("FAIL frame_error: got fe/cv/busy/strobe=%b required 1000",
                           {frame_error, cmd_valid, busy, strobe_out});
    end
    step();
    checks++;
    if ({frame_error, strobe_out, cmd_valid} !== 3'b000) begin
      failures++; $display("FAIL frame_after: got fe/strobe/cv=%b required 000", {frame_error, strobe_out, cmd_valid});
    end
  endtask

  task automatic test_timeout();
    int n;
    logic seen_strobe;
    cmd_in = 40'h4C_0000_0000; strobe_in = 1'b1;
    step(); step();
    strobe_in = 1'b0;
    checks++;
    if (cmd_valid !== 1'b1) begin
      failures++; $display("FAIL timeout_cv: got %b required 1", cmd_valid);
    end
    n = 0; seen_strobe = 1'b0;
    while (n < 40 && resp_timeout !== 1'b1) begin
      step();
      n++;
      if (strobe_out === 1'b1) seen_strobe = 1'b1;
    end
    checks++;
    if (n !== 16) begin
      failures++; $display("FAIL timeout_cycles: got %0d cycles after cmd_valid required 16", n);
    end
    checks++;
    if ({busy, seen_strobe} !== 2'b00) begin
      failures++; $display("FAIL timeout_idle: got busy=%b strobe_seen=%b required 0 0", busy, seen_strobe);
    end
    step();
    checks++;
    if (resp_timeout !== 1'b0) begin
      failures++; $display("FAIL timeout_pulse: got %b required 0", resp_timeout);
    end
  endtask

  task automatic test_illegal_index();
    cmd_in = 40'h45_0000_0000; strobe_in = 1'b1;
    step(); step();
    strobe_in = 1'b0;
`ifdef CMD_LEGAL_CHECK_EN
    checks++;
    if ({index_error, cmd_valid} !== 2'b10) begin
      failures++; $display("FAIL illegal_flags: got ie/cv=%b required 10", {index_error, cmd_valid});
    end
    step();
    checks++;
    if ({strobe_out, resp_out} !== {1'b1, 40'h05_0040_0000}) begin
      failures++; $display("FAIL illegal_resp: got strobe=%b resp=%h required 1 0500400000", strobe_out, resp_out);
    end
`else
    checks++;
    if ({index_error, cmd_valid, cmd_index} !== {2'b01, 6'd5}) begin
      failures++; $display("FAIL legal5_cv: got ie=%b cv=%b idx=%0d required 0 1 5", index_error, cmd_valid, cmd_index);
    end
    core_resp_valid = 1'b1; core_resp = 32'h0000_ABCD;
    step();
    core_resp_valid = 1'b0;
    step();
    checks++;
    if ({strobe_out, resp_out} !== {1'b1, 40'h05_0000_ABCD}) begin
      failures++; $display("FAIL legal5_resp: got strobe=%b resp=%h required 1 050000abcd", strobe_out, resp_out);
    end
`endif
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
  endtask

  task automatic test_backpressure();
    logic seen_strobe;
    serial_ready = 1'b0;
    cmd_in = 40'h48_0000_00AA; strobe_in = 1'b1;
    step(); step();
    core_resp_valid = 1'b1; core_resp = 32'h0000_5A5A;
    step();
    core_resp_valid = 1'b0;
    seen_strobe = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (strobe_out !== 1'b0) seen_strobe = 1'b1;
    end
    checks++;
    if (seen_strobe !== 1'b0) begin
      failures++; $display("FAIL bp_stalled: got strobe during stall=%b required 0", seen_strobe);
    end
    serial_ready = 1'b1;
    step();
    checks++;
    if ({strobe_out, resp_out} !== {1'b1, 40'h08_0000_5A5A}) begin
      failures++; $display("FAIL bp_resp: got strobe=%b resp=%h required 1 0800005a5a", strobe_out, resp_out);
    end
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    seen_strobe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ack_out !== 1'b0 || busy !== 1'b0) seen_strobe = 1'b1;
    end
    checks++;
    if (seen_strobe !== 1'b0) begin
      failures++; $display("FAIL level_retrigger: got ack/busy while strobe_in held=%b required 0", seen_strobe);
    end
    strobe_in = 1'b0;
    step();
  endtask

  task automatic test_reset_in_wait_ack();
    cmd_in = 40'h43_0000_0001; strobe_in = 1'b1;
    step(); step();
    strobe_in = 1'b0;
    core_resp_valid = 1'b1; core_resp = 32'h0000_0001;
    step();
    core_resp_valid = 1'b0;
    step();
    checks++;
    if (strobe_out !== 1'b1) begin
      failures++; $display("FAIL rst_pre_strobe: got %b required 1", strobe_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({strobe_out, resp_out, busy} !== 42'd0) begin
      failures++; $display("FAIL rst_async: got strobe=%b resp=%h busy=%b required 0 0 0", strobe_out, resp_out, busy);
    end
    step();
    reset = 1'b0;
    step();
    cmd_in = 40'h50_0000_0077; strobe_in = 1'b1;
    step();
    checks++;
    if (ack_out !== 1'b1) begin
      failures++; $display("FAIL rst_post_ack: got %b required 1", ack_out);
    end
    step();
    strobe_in = 1'b0;
    checks++;
    if ({cmd_valid, cmd_index, cmd_argument} !== {1'b1, 6'd16, 32'h77}) begin
      failures++; $display("FAIL rst_post_cv: got cv=%b idx=%0d arg=%h required 1 16 00000077",
                           cmd_valid, cmd_index, cmd_argument);
    end
    core_resp_valid = 1'b1; core_resp = 32'h0000_0123;
    step();
    core_resp_valid = 1'b0;
    step();
    checks++;
    if ({strobe_out, resp_out} !== {1'b1, 40'h10_0000_0123}) begin
      failures++; $display("FAIL rst_post_resp: got strobe=%b resp=%h required 1 1000000123", strobe_out, resp_out);
    end
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    checks++;
    if ({strobe_out, busy} !== 2'b00) begin
      failures++; $display("FAIL rst_post_ack_done: got strobe=%b busy=%b required 0 0", strobe_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_frame_error();
    test_timeout();
    test_illegal_index();
    test_backpressure();
    test_reset_in_wait_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
